// File: rtl/parking_billing_ledger_if.sv
// Receipt stream between the billing ledger and the display/printer.
// The ledger drives the receipt fields; the consumer drives rcpt_ready.
interface parking_billing_ledger_if #(
  parameter int COST_W = 9,
  parameter int TIME_W = 8
);
  logic              rcpt_valid;
  logic              rcpt_ready;
  logic [1:0]        rcpt_car_id;
  logic [COST_W-1:0] rcpt_cost;
  logic [TIME_W-1:0] rcpt_time;

  modport master (
    output rcpt_valid, rcpt_car_id, rcpt_cost, rcpt_time,
    input  rcpt_ready
  );

  modport slave (
    input  rcpt_valid, rcpt_car_id, rcpt_cost, rcpt_time,
    output rcpt_ready
  );
endinterface

// File: rtl/parking_billing_ledger.sv
// Billing stage of the parking controller: caps each exit charge, keeps daily revenue
// and queues one receipt per exit in a small fall-through FIFO.
module parking_billing_ledger #(
  parameter int COST_W     = 9,
  parameter int TIME_W     = 8,
  parameter int REV_W      = 16,
  parameter int COST_CAP   = 400,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          exit_valid,
  input  logic [1:0]                    Car_Id,
  input  logic [COST_W-1:0]             Ccost,
  input  logic [TIME_W-1:0]             current_time,
  input  logic                          close_day,
  parking_billing_ledger_if.master      rcpt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [REV_W-1:0]              total_revenue,
  output logic [REV_W-1:0]              last_day_revenue,
  output logic                          rev_sat,
  output logic [7:0]                    drop_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 + COST_W + TIME_W;
  localparam logic [COST_W-1:0] CAP_VAL = COST_W'(COST_CAP);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic [COST_W-1:0]  charged;
  logic               full, pop, push_ok, drop;
  logic [REV_W-1:0]   rev_base;
  logic [REV_W:0]     rev_sum;
  logic               rev_ovf;
  logic [7:0]         drop_base;

  assign charged = (Ccost > CAP_VAL) ? CAP_VAL : Ccost;
  assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop     = rcpt.rcpt_valid & rcpt.rcpt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = exit_valid & (~full | pop);
  assign drop    = exit_valid & full & ~pop;

  assign head             = mem[rd_ptr];
  assign rcpt.rcpt_valid  = (fifo_count != '0);
  assign rcpt.rcpt_car_id = rcpt.rcpt_valid ? head[ENTRY_W-1 -: 2] : '0;
  assign rcpt.rcpt_cost   = rcpt.rcpt_valid ? head[TIME_W +: COST_W] : '0;
  assign rcpt.rcpt_time   = rcpt.rcpt_valid ? head[TIME_W-1:0] : '0;

  // close_day restarts the day before the same-cycle exit is added in.
  always_comb begin
    rev_base  = close_day ? '0 : total_revenue;
    rev_sum   = {1'b0, rev_base} + (REV_W+1)'(charged);
    rev_ovf   = rev_sum[REV_W];
    drop_base = close_day ? 8'd0 : drop_count;
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= {Car_Id, charged, current_time};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_count       <= '0;
      total_revenue    <= '0;
      last_day_revenue <= '0;
      rev_sat          <= 1'b0;
      drop_count       <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (close_day) last_day_revenue <= total_revenue;

      if (exit_valid) total_revenue <= rev_ovf ? '1 : rev_sum[REV_W-1:0];
      else            total_revenue <= rev_base;

      rev_sat <= (close_day ? 1'b0 : rev_sat) | (exit_valid & rev_ovf);

      if (drop && drop_base != 8'hFF) drop_count <= drop_base + 8'd1;
      else                            drop_count <= drop_base;
    end
  end

endmodule

// File: tb/tb_parking_billing_ledger.sv
// Directed bench for parking_billing_ledger: receipts, capping, drops, saturation,
// day close and mid-operation reset, with hand-computed expectations.
module tb_parking_billing_ledger;

  logic        clk = 1'b0;
  logic        reset;
  logic        exit_valid;
  logic [1:0]  Car_Id;
  logic [8:0]  Ccost;
  logic [7:0]  current_time;
  logic        close_day;
  logic [2:0]  fifo_count;
  logic [15:0] total_revenue;
  logic [15:0] last_day_revenue;
  logic        rev_sat;
  logic [7:0]  drop_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  parking_billing_ledger_if #(.COST_W(9), .TIME_W(8)) rcpt_bus ();

  parking_billing_ledger dut (
    .clk              (clk),
    .reset            (reset),
    .exit_valid       (exit_valid),
    .Car_Id           (Car_Id),
    .Ccost            (Ccost),
    .current_time     (current_time),
    .close_day        (close_day),
    .rcpt             (rcpt_bus),
    .fifo_count       (fifo_count),
    .total_revenue    (total_revenue),
    .last_day_revenue (last_day_revenue),
    .rev_sat          (rev_sat),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic exit_car(input logic [1:0] id, input logic [8:0] cost, input logic [7:0] t);
    exit_valid   = 1'b1;
    Car_Id       = id;
    Ccost        = cost;
    current_time = t;
    tick();
    exit_valid   = 1'b0;
  endtask

  logic [1:0] exp_id   [4];
  logic [8:0] exp_cost [4];
  logic [7:0] exp_time [4];

  initial begin
    reset = 1'b1; exit_valid = 1'b0; Car_Id = '0; Ccost = '0; current_time = '0;
    close_day = 1'b0; rcpt_bus.rcpt_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("reset_valid", 32'(rcpt_bus.rcpt_valid), 0);
    check("reset_count", 32'(fifo_count), 0);
    check("reset_total", 32'(total_revenue), 0);
    check("reset_drop",  32'(drop_count), 0);

    // first receipt
    exit_car(2'd2, 9'd120, 8'h15);
    check("t1_valid", 32'(rcpt_bus.rcpt_valid), 1);
    check("t1_id",    32'(rcpt_bus.rcpt_car_id), 2);
    check("t1_cost",  32'(rcpt_bus.rcpt_cost), 120);
    check("t1_time",  32'(rcpt_bus.rcpt_time), 32'h15);
    check("t1_total", 32'(total_revenue), 120);
    check("t1_count", 32'(fifo_count), 1);

    // capped charge
    exit_car(2'd1, 9'd511, 8'h20);
    check("t2_count", 32'(fifo_count), 2);
    check("t2_total", 32'(total_revenue), 520);
    check("t2_head_hold", 32'(rcpt_bus.rcpt_car_id), 2);
    rcpt_bus.rcpt_ready = 1'b1;
    tick();
    check("t2_cap_cost", 32'(rcpt_bus.rcpt_cost), 400);
    check("t2_id",       32'(rcpt_bus.rcpt_car_id), 1);
    tick();
    check("t2_empty", 32'(rcpt_bus.rcpt_valid), 0);
    rcpt_bus.rcpt_ready = 1'b0;

    // overflow the FIFO by one
    exit_car(2'd0, 9'd10, 8'd1);
    exit_car(2'd1, 9'd20, 8'd2);
    exit_car(2'd2, 9'd30, 8'd3);
    exit_car(2'd3, 9'd40, 8'd4);
    exit_car(2'd0, 9'd50, 8'd5);
    check("t3_count", 32'(fifo_count), 4);
    check("t3_drop",  32'(drop_count), 1);
    check("t3_total", 32'(total_revenue), 670);
    rcpt_bus.rcpt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_pop_id",   32'(rcpt_bus.rcpt_car_id), 32'(i));
      check("t3_pop_cost", 32'(rcpt_bus.rcpt_cost), 32'((i + 1) * 10));
      check("t3_pop_time", 32'(rcpt_bus.rcpt_time), 32'(i + 1));
      tick();
    end
    check("t3_drained", 32'(rcpt_bus.rcpt_valid), 0);
    rcpt_bus.rcpt_ready = 1'b0;

    // push and pop together while full
    exit_car(2'd3, 9'd100, 8'h30);
    exit_car(2'd2, 9'd101, 8'h31);
    exit_car(2'd1, 9'd102, 8'h32);
    exit_car(2'd0, 9'd103, 8'h33);
    check("t4_full", 32'(fifo_count), 4);
    rcpt_bus.rcpt_ready = 1'b1;
    exit_car(2'd1, 9'd7, 8'h40);
    check("t4_count", 32'(fifo_count), 4);
    check("t4_drop",  32'(drop_count), 1);
    check("t4_total", 32'(total_revenue), 1083);
    exp_id[0] = 2'd2; exp_cost[0] = 9'd101; exp_time[0] = 8'h31;
    exp_id[1] = 2'd1; exp_cost[1] = 9'd102; exp_time[1] = 8'h32;
    exp_id[2] = 2'd0; exp_cost[2] = 9'd103; exp_time[2] = 8'h33;
    exp_id[3] = 2'd1; exp_cost[3] = 9'd7;   exp_time[3] = 8'h40;
    for (int i = 0; i < 4; i++) begin
      check("t4_pop_id",   32'(rcpt_bus.rcpt_car_id), 32'(exp_id[i]));
      check("t4_pop_cost", 32'(rcpt_bus.rcpt_cost), 32'(exp_cost[i]));
      check("t4_pop_time", 32'(rcpt_bus.rcpt_time), 32'(exp_time[i]));
      tick();
    end
    check("t4_drained", 32'(fifo_count), 0);

    // close the day to start clean
    close_day = 1'b1;
    tick();
    close_day = 1'b0;
    check("close_last",  32'(last_day_revenue), 1083);
    check("close_total", 32'(total_revenue), 0);
    check("close_drop",  32'(drop_count), 0);

    // climb to 0xFF00, then saturate
    for (int i = 0; i < 163; i++) exit_car(2'(i), 9'd400, 8'(i));
    exit_car(2'd0, 9'd80, 8'hA0);
    check("t5_pre",     32'(total_revenue), 32'hFF00);
    check("t5_pre_sat", 32'(rev_sat), 0);
    exit_car(2'd1, 9'd400, 8'hA1);
    check("t5_sat_total", 32'(total_revenue), 32'hFFFF);
    check("t5_sat_flag",  32'(rev_sat), 1);
    exit_car(2'd2, 9'd400, 8'hA2);
    check("t5_sat_hold", 32'(total_revenue), 32'hFFFF);
    close_day = 1'b1;
    exit_car(2'd3, 9'd50, 8'hA3);
    close_day = 1'b0;
    check("t5_last",  32'(last_day_revenue), 32'hFFFF);
    check("t5_total", 32'(total_revenue), 50);
    check("t5_sat",   32'(rev_sat), 0);
    tick(); tick();
    check("t5_drained", 32'(fifo_count), 0);
    rcpt_bus.rcpt_ready = 1'b0;

    // reset with pending receipts and a simultaneous exit
    exit_car(2'd1, 9'd1, 8'd1);
    exit_car(2'd2, 9'd2, 8'd2);
    exit_car(2'd3, 9'd3, 8'd3);
    check("t6_pending", 32'(fifo_count), 3);
    reset = 1'b1;
    exit_car(2'd0, 9'd9, 8'd9);
    reset = 1'b0;
    check("t6_valid", 32'(rcpt_bus.rcpt_valid), 0);
    check("t6_count", 32'(fifo_count), 0);
    check("t6_total", 32'(total_revenue), 0);
    check("t6_last",  32'(last_day_revenue), 0);
    check("t6_sat",   32'(rev_sat), 0);
    check("t6_drop",  32'(drop_count), 0);
    check("t6_cost",  32'(rcpt_bus.rcpt_cost), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
